// File: rtl/buffer_b_reader.sv
// B-operand buffer read sequencer: credited fixed-latency reads into a small FIFO, streamed out over valid/ready.
// Optional feature: define BUFFER_B_READER_PERF_EN to build the saturating credit-stall counter on stall_cycles.
module buffer_b_reader #(
  parameter int BUFFER_ADDR_WIDTH = 9,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [BUFFER_ADDR_WIDTH:0]   cmd_len,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_stride,
  output logic                         mm_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] mm_read_addr,
  input  logic                         mm_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0] mm_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         done,
  output logic [31:0]                  stall_cycles
);
  localparam int AW = BUFFER_ADDR_WIDTH;
  localparam int DW = BUFFER_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t          state, state_next;
  logic [AW:0]     len_q, issue_cnt, recv_cnt;
  logic [AW-1:0]   stride_q, next_addr;
  logic [CW-1:0]   outstanding, fifo_count;
  logic [CW:0]     in_use;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [DW-1:0]   mem_data [FIFO_DEPTH];
  logic            mem_last [FIFO_DEPTH];
  logic            accept, credit, issue, push, pop, done_next;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  // Requests on the wire plus queued rows may never exceed the FIFO, so a stalled consumer cannot lose data.
  assign in_use    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit    = in_use < (CW+1)'(FIFO_DEPTH);
  assign push      = mm_read_data_valid && (outstanding != '0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem_data[rd_ptr] : '0;
  assign out_last  = out_valid && mem_last[rd_ptr];

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            done_next = 1'b1;
          end else begin
            issue      = 1'b1;
            state_next = (cmd_len == (AW+1)'(1)) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit) begin
          issue = 1'b1;
          if (issue_cnt == len_q - (AW+1)'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (recv_cnt == len_q && fifo_count == CW'(1) && pop) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      done               <= 1'b0;
      mm_read_addr_valid <= 1'b0;
      mm_read_addr       <= '0;
      len_q              <= '0;
      stride_q           <= '0;
      next_addr          <= '0;
      issue_cnt          <= '0;
      recv_cnt           <= '0;
      outstanding        <= '0;
    end else begin
      state              <= state_next;
      done               <= done_next;
      mm_read_addr_valid <= issue;
      mm_read_addr       <= !issue ? '0 : (accept ? cmd_base_addr : next_addr);
      if (accept) begin
        len_q     <= cmd_len;
        stride_q  <= cmd_stride;
        next_addr <= cmd_base_addr + cmd_stride;
        issue_cnt <= issue ? (AW+1)'(1) : '0;
        recv_cnt  <= '0;
      end else begin
        if (issue) begin
          next_addr <= next_addr + stride_q;
          issue_cnt <= issue_cnt + (AW+1)'(1);
        end
        if (push) recv_cnt <= recv_cnt + (AW+1)'(1);
      end
      case ({issue, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // NOTE: the row storage is reset with everything else so out_data reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= mm_read_data;
        mem_last[wr_ptr] <= (recv_cnt == len_q - (AW+1)'(1));
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef BUFFER_B_READER_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (state == ISSUE && !credit && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_buffer_b_reader.sv
// Self-checking bench for buffer_b_reader: 4-cycle buffer model, randomized tiles, queue-based row/address model.
module tb_buffer_b_reader;
  localparam int AW    = 9;
  localparam int DW    = 512;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [AW:0]   cmd_len = '0;
  logic [AW-1:0] cmd_stride = '0;
  logic          mm_read_addr_valid;
  logic [AW-1:0] mm_read_addr;
  logic          mm_read_data_valid = 1'b0;
  logic [DW-1:0] mm_read_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          done;
  logic [31:0]   stall_cycles;

  buffer_b_reader #(.BUFFER_ADDR_WIDTH(AW), .BUFFER_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len), .cmd_stride(cmd_stride),
    .mm_read_addr_valid(mm_read_addr_valid), .mm_read_addr(mm_read_addr),
    .mm_read_data_valid(mm_read_data_valid), .mm_read_data(mm_read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Tile model: expected addresses and rows follow base + k*stride modulo 2^AW.
  logic [AW-1:0] tile_base, tile_stride;
  int            tile_len = 0;
  logic [31:0]   salt = 32'h1234_5678;
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] got_addr_q[$];
  int issued = 0, popped = 0, pop_idx = 0;
  int accept_cyc = 0, first_issue_cyc = 0, last_issue_cyc = 0;
  int first_valid_cyc = 0, last_pop_cyc = -10;
  bit saw_valid = 1'b0;
  int ready_mode = 0;
  int ready_release = 0;

  logic          pv[4];
  logic [AW-1:0] pa[4];
  bit            hold_pending = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_last;

  function automatic logic [AW-1:0] model_addr(input int k);
    int a;
    a = (int'(tile_base) + k * int'(tile_stride)) % (1 << AW);
    return a[AW-1:0];
  endfunction

  function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a, input logic [31:0] s);
    logic [DW-1:0] r;
    logic [31:0]   h;
    h = {23'd0, a} * 32'h9E37_79B1;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = h ^ s ^ (32'(i) * 32'h0101_0101);
    return r;
  endfunction

  // Buffer model (fixed 4-cycle latency), request monitor and consumer, all on the falling edge.
  always @(negedge clk) begin
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    logic          exp_l;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] = 1'b0;
        pa[i] = '0;
      end
      mm_read_data_valid = 1'b0;
      mm_read_data       = '0;
      hold_pending       = 1'b0;
    end else begin
      mm_read_data_valid = pv[3];
      mm_read_data       = pv[3] ? row_of(pa[3], salt) : '0;
      for (int i = 3; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = mm_read_addr_valid;
      pa[0] = mm_read_addr;

      if (mm_read_addr_valid === 1'b1) begin
        got_addr_q.push_back(mm_read_addr);
        if (issued == 0) first_issue_cyc = cyc;
        last_issue_cyc = cyc;
        issued++;
        total++;
        if (exp_addr_q.size() == 0) begin
          bad++;
          $display("FAIL req_addr cyc=%0d got=%h required=no request", cyc, mm_read_addr);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (mm_read_addr !== exp_a) begin
            bad++;
            $display("FAIL req_addr cyc=%0d got=%h required=%h", cyc, mm_read_addr, exp_a);
          end
        end
        total++;
        if (issued - popped > DEPTH) begin
          bad++;
          $display("FAIL credit cyc=%0d got in_use=%0d required<=%0d", cyc, issued - popped, DEPTH);
        end
      end else begin
        total++;
        if (mm_read_addr !== '0) begin
          bad++;
          $display("FAIL idle_addr cyc=%0d got=%h required=0", cyc, mm_read_addr);
        end
      end

      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (cyc >= ready_release);
      endcase

      if (hold_pending) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d got valid=%b last=%b data=%h required valid=1 last=%b data=%h",
                   cyc, out_valid, out_last, out_data[31:0], held_last, held_data[31:0]);
        end
      end
      if (out_valid === 1'b1 && !saw_valid) begin
        saw_valid       = 1'b1;
        first_valid_cyc = cyc;
      end
      if (out_valid === 1'b1 && out_ready) begin
        total++;
        if (pop_idx >= tile_len) begin
          bad++;
          $display("FAIL extra_row cyc=%0d got row %0d required %0d rows", cyc, pop_idx, tile_len);
        end else begin
          exp_d = row_of(model_addr(pop_idx), salt);
          exp_l = (pop_idx == tile_len - 1);
          if (out_data !== exp_d || out_last !== exp_l) begin
            bad++;
            $display("FAIL row%0d got data=%h last=%b required data=%h last=%b",
                     pop_idx, out_data[31:0], out_last, exp_d[31:0], exp_l);
          end
          if (exp_l) last_pop_cyc = cyc;
        end
        pop_idx++;
        popped++;
      end
      hold_pending = (out_valid === 1'b1) && !out_ready;
      held_data    = out_data;
      held_last    = out_last;
    end
  end

  task automatic start_tile(input logic [AW-1:0] base, input int len, input logic [AW-1:0] stride,
                            input int mode, input string name);
    @(negedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_cmd_ready got=%b required=1", name, cmd_ready);
    end
    tile_base   = base;
    tile_stride = stride;
    tile_len    = len;
    salt        = $urandom;
    pop_idx     = 0;
    issued      = 0;
    popped      = 0;
    saw_valid   = 1'b0;
    last_pop_cyc  = -10;
    ready_release = 1 << 30;
    ready_mode    = mode;
    exp_addr_q.delete();
    got_addr_q.delete();
    for (int k = 0; k < len; k++) exp_addr_q.push_back(model_addr(k));
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_len       = (AW+1)'(len);
    cmd_stride    = stride;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic finish_tile(input string name, input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done got=no pulse in %0d cycles required=pulse", name, budget);
    end else begin
      total++;
      if (cyc != last_pop_cyc + 1) begin
        bad++;
        $display("FAIL %s_done_timing got cyc=%0d required=%0d", name, cyc, last_pop_cyc + 1);
      end
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_width got=%b required=0", name, done);
    end
    total++;
    if (pop_idx != tile_len) begin
      bad++;
      $display("FAIL %s_rows got=%0d required=%0d", name, pop_idx, tile_len);
    end
    total++;
    if (issued != tile_len || exp_addr_q.size() != 0) begin
      bad++;
      $display("FAIL %s_requests got=%0d required=%0d", name, issued, tile_len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b1 || mm_read_addr_valid !== 1'b0 || mm_read_addr !== '0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_last !== 1'b0 || done !== 1'b0 || stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b req=%b addr=%h oval=%b last=%b done=%b stall=%0d required 1 0 0 0 0 0 0",
               cmd_ready, mm_read_addr_valid, mm_read_addr, out_valid, out_last, done, stall_cycles);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      total++;
      if (cmd_ready !== 1'b1 || mm_read_addr_valid !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 ||
          out_data !== '0) begin
        bad++;
        $display("FAIL idle_outputs cyc=%0d got ready=%b req=%b oval=%b done=%b required 1 0 0 0",
                 cyc, cmd_ready, mm_read_addr_valid, out_valid, done);
      end
    end
  endtask

  task automatic test_basic();
    start_tile(9'h010, 4, 9'h001, 0, "basic");
    finish_tile("basic", 100);
    total++;
    if (got_addr_q.size() != 4) begin
      bad++;
      $display("FAIL basic_addr_count got=%0d required=4", got_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_addr_q[i] !== AW'(16 + i)) begin
          bad++;
          $display("FAIL basic_addr%0d got=%h required=%h", i, got_addr_q[i], AW'(16 + i));
        end
      end
    end
    // Acceptance handshake cycle is accept_cyc-1; requests start the next cycle, rows six cycles after acceptance.
    total++;
    if (first_issue_cyc != accept_cyc || last_issue_cyc - first_issue_cyc != 3) begin
      bad++;
      $display("FAIL basic_issue_cycles got first=%0d last=%0d required first=%0d last=%0d",
               first_issue_cyc, last_issue_cyc, accept_cyc, accept_cyc + 3);
    end
    total++;
    if (first_valid_cyc - accept_cyc != 5) begin
      bad++;
      $display("FAIL basic_latency got=%0d required=5", first_valid_cyc - accept_cyc);
    end
  endtask

  task automatic test_wrap_stride();
    logic [AW-1:0] want[3];
    want[0] = 9'h1F0;
    want[1] = 9'h1FC;
    want[2] = 9'h008;
    start_tile(9'h1F0, 3, 9'h00C, 0, "wrap");
    finish_tile("wrap", 100);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_addr_q.size() <= i || got_addr_q[i] !== want[i]) begin
        bad++;
        $display("FAIL wrap_addr%0d got=%h required=%h", i,
                 (got_addr_q.size() > i) ? got_addr_q[i] : '0, want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    start_tile(AW'($urandom), 20, AW'($urandom_range(1, 511)), 2, "bp");
    ready_release = accept_cyc + 30;
    repeat (29) @(negedge clk);
    #1;
    total++;
    if (issued != DEPTH) begin
      bad++;
      $display("FAIL bp_issue_before_stall got=%0d required=%0d", issued, DEPTH);
    end
    finish_tile("bp", 200);
`ifdef BUFFER_B_READER_PERF_EN
    total++;
    if (stall_cycles == 32'd0) begin
      bad++;
      $display("FAIL bp_stall_cycles got=%0d required>0", stall_cycles);
    end
`else
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL bp_stall_cycles got=%0d required=0", stall_cycles);
    end
`endif
  endtask

  task automatic test_zero_len();
    start_tile(AW'($urandom), 0, AW'($urandom), 0, "zero");
    @(negedge clk); #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL zero_done got=%b required=1", done);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL zero_done_width got=%b required=0", done);
    end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (issued != 0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_requests got=%0d ready=%b required=0 ready=1", issued, cmd_ready);
    end
  endtask

  task automatic test_max_len();
    start_tile(AW'($urandom), 512, 9'h001, 0, "max");
    finish_tile("max", 1000);
    total++;
    if (got_addr_q.size() != 512) begin
      bad++;
      $display("FAIL max_addr_count got=%0d required=512", got_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_tile();
    bit reached = 1'b0;
    start_tile(AW'($urandom), 10, AW'($urandom), 0, "midrst");
    for (int n = 0; n < 50; n++) begin
      @(negedge clk); #1;
      if (issued == 10) begin
        reached = 1'b1;
        break;
      end
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL midrst_issue got=%0d required=10", issued);
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1 || mm_read_addr_valid !== 1'b0 || mm_read_addr !== '0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_last !== 1'b0 || done !== 1'b0 || stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL midrst_outputs got ready=%b req=%b addr=%h oval=%b last=%b done=%b required 1 0 0 0 0 0",
               cmd_ready, mm_read_addr_valid, mm_read_addr, out_valid, out_last, done);
    end
    tile_len = 0;
    exp_addr_q.delete();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk); #1;
      total++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_quiet got done=%b oval=%b required 0 0", done, out_valid);
      end
    end
    rst_n = 1'b1;
    start_tile(AW'($urandom), 2, AW'($urandom), 1, "after_rst");
    finish_tile("after_rst", 100);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      start_tile(AW'($urandom), $urandom_range(1, 24), AW'($urandom), 1, "rand");
      finish_tile("rand", 400);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap_stride();
    test_backpressure();
    test_zero_len();
    test_max_len();
    test_reset_mid_tile();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog got=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/buffer_b_reader.md
Name: buffer_b_reader

Overview:
- Matrix-multiply-side read sequencer for the B operand buffer. It accepts a tile command (base, row count, stride) and issues one read per cycle on the buffer's fixed-latency read port.
- It captures returning rows into a small output FIFO and presents them to the MM datapath over valid/ready, tagging the final row.
- A credit counter ensures rows in flight plus FIFO occupancy never exceed FIFO depth, so downstream backpressure never drops data.

Parameters:
- BUFFER_ADDR_WIDTH, 9, buffer address width (AW).
- BUFFER_DATA_WIDTH, 512, row width (DW).
- FIFO_DEPTH, 8, output FIFO entries. Power of two, at least 2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  tile command valid
- cmd_ready  output  1  sequencer idle, command accepted when valid&&ready
- cmd_base_addr  input  AW  first row address
- cmd_len  input  AW+1  rows to read, 0..2^AW
- cmd_stride  input  AW  address increment per row
- mm_read_addr_valid  output  1  read request to buffer
- mm_read_addr  output  AW  read address
- mm_read_data_valid  input  1  buffer response valid
- mm_read_data  input  DW  buffer response data
- out_valid  output  1  row available
- out_ready  input  1  consumer accepts row
- out_data  output  DW  row data
- out_last  output  1  final row of tile
- done  output  1  one-cycle pulse, tile fully delivered
- stall_cycles  output  32  credit-stall counter (see Optional Feature)

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1; mm_read_addr_valid=0; mm_read_addr=0; out_valid=0; out_data=0; out_last=0; done=0; all counters and the FIFO cleared. The buffer shares rst_n, so no stale responses survive reset. Reset mid-tile aborts the tile silently, with no done pulse.
- FSM states:
  - IDLE: cmd_ready=1. Accept with cmd_len=0 -> done pulses next cycle, stay IDLE. Accept with cmd_len>0 -> latch base, len, stride; issue_cnt=0, recv_cnt=0; go to ISSUE.
  - ISSUE: cmd_ready=0. Each cycle with credit, drive mm_read_addr_valid=1 and mm_read_addr=base+issue_cnt*stride (mod 2^AW, wraps silently), then increment issue_cnt. When issue_cnt reaches len -> DRAIN.
  - DRAIN: no issues. When recv_cnt==len and the last row has been popped -> done=1 for one cycle, go to IDLE.
- Issue outputs are registered. First request appears in the cycle after command acceptance. mm_read_addr is 0 whenever valid is low.
- Credit rule: issue only if outstanding + fifo_count < FIFO_DEPTH.
  - outstanding is incremented on issue and decremented on mm_read_data_valid.
  - Simultaneous issue and response leaves it unchanged.
- Response handling: buffer latency is fixed at 4 cycles from mm_read_addr_valid to mm_read_data_valid, and order is preserved. Every response is pushed into the FIFO with last = (recv_cnt == len-1). The push occupies a FIFO entry in the same cycle it is counted, with no bypass. out_valid rises the cycle after the push.
- Output handshake: pop on out_valid && out_ready. out_data and out_last stay stable while out_valid && !out_ready. Push and pop in the same cycle keep fifo_count constant. Full-throughput streaming at 1 row/cycle when out_ready is held high.
- The credit rule makes FIFO overflow impossible. A response with outstanding==0 is dropped.
- Latency: with out_ready=1, the first out_valid is 6 cycles after command acceptance. done comes 1 cycle after the last pop.

Optional Feature:
- Macro BUFFER_B_READER_PERF_EN.
- Defined: stall_cycles is a 32-bit saturating counter. It increments each cycle in ISSUE with no credit, clears on reset and on command acceptance, and holds its value after done.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Reset, idle: hold rst_n low then release -> cmd_ready=1, all other outputs 0, no mm_read_addr_valid for 20 cycles.
- Basic tile: base=0x010, len=4, stride=1, out_ready=1 -> addresses 0x010..0x013 on 4 consecutive cycles. Rows out in order, out_last only on the 4th, done one cycle after the 4th pop.
- Wrap and stride: base=0x1F0, len=3, stride=0x0C (AW=9) -> addresses 0x1F0, 0x1FC, 0x008.
- Backpressure: len=20, out_ready=0 for 30 cycles then 1 -> exactly 8 requests issued before stall. No data lost, 20 rows delivered in order. With PERF_EN, stall_cycles>0.
- Zero length and max length: len=0 -> done pulse next cycle with no requests. len=512, stride=1 -> 512 rows, out_last on row 511.
- Reset mid-tile: assert rst_n during DRAIN of len=10 -> all outputs 0 immediately. A following len=2 tile completes normally.
